// File: rtl/clk_switch_ctrl_pkg.sv
// clk_switch_pkg: shared types and constants for the CPU clock switch controller.
//   state_t          - controller FSM states
//   BBC_REGION_BASE  - first cpu_adr_hi value routed to the BBC bus
//   HS_DIV_DEFAULT   - default hsclk cycles per high-speed CPU clock phase
package clk_switch_pkg;

   localparam int HS_DIV_DEFAULT = 2;
   localparam logic [7:0] BBC_REGION_BASE = 8'h80;

   typedef enum logic [2:0] {
      HS_LO,
      HS_HI,
      BBC_WAIT_LO,
      BBC_WAIT_HI,
      BBC_HI
   } state_t;

   function automatic logic is_bbc_state(input state_t s);
      return s inside {BBC_WAIT_LO, BBC_WAIT_HI, BBC_HI};
   endfunction

   // A cycle goes to the BBC bus when high speed is off, or when it is a real
   // bus access into the upper half of the address map.
   function automatic logic bbc_target(input logic hs_en, input logic valid, input logic [7:0] adr_hi);
      return !hs_en || (valid && adr_hi >= BBC_REGION_BASE);
   endfunction

endpackage

// File: rtl/clk_switch_ctrl_if.sv
// clk_switch_ctrl_if: CPU-side bus of the clock switch controller.
//   cpu_adr_hi, cpu_vda, cpu_vpa - address high byte and valid strobes from the CPU
//   cpu_phi2                     - CPU clock produced by the controller
//   bbc_cycle, ram_sel           - per-cycle routing flags produced by the controller
interface clk_switch_ctrl_if;

   logic [7:0] cpu_adr_hi;
   logic       cpu_vda;
   logic       cpu_vpa;
   logic       cpu_phi2;
   logic       bbc_cycle;
   logic       ram_sel;

   modport master (
      output cpu_adr_hi, cpu_vda, cpu_vpa,
      input  cpu_phi2, bbc_cycle, ram_sel
   );

   modport slave (
      input  cpu_adr_hi, cpu_vda, cpu_vpa,
      output cpu_phi2, bbc_cycle, ram_sel
   );

endinterface

// File: rtl/clk_switch_ctrl_sync_bit.sv
// sync_bit: multi-flop synchroniser for a single asynchronous bit.
//   clk    - destination clock
//   resetb - synchronous active-low reset, clears every stage
//   d      - asynchronous input
//   q      - synchronised output (last stage)
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic resetb,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk)
      if (!resetb) sr <= '0;
      else         sr <= (sr << 1) | STAGES'(d);

   assign q = sr[STAGES-1];

endmodule

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: generates the CPU clock, running fast cycles from hsclk and
// stretching BBC-bus cycles so their high phase is locked to bbc_phi0.
//   hsclk      - single clock, all state changes on its rising edge
//   resetb     - synchronous active-low reset
//   bbc_phi0   - BBC 2 MHz phase-0 clock, asynchronous to hsclk
//   cfg_hs_en  - high-speed enable; 0 forces every cycle onto the BBC bus
//   bus        - CPU address/strobes in, cpu_phi2/bbc_cycle/ram_sel out
module clk_switch_ctrl
   import clk_switch_pkg::*;
#(
   parameter int HS_DIV      = HS_DIV_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic               hsclk,
   input  logic               resetb,
   input  logic               bbc_phi0,
   input  logic               cfg_hs_en,
   clk_switch_ctrl_if.slave   bus
);

   localparam int CW = $clog2(HS_DIV + 1);
   localparam int SW = $clog2(SYNC_STAGES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(HS_DIV - 1);

   state_t        state, nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [SW-1:0] settle;
   logic          phi0_s, settled, valid, last;
   logic          phi2, phi2_nxt, ram, ram_nxt;

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk    (hsclk),
      .resetb (resetb),
      .d      (bbc_phi0),
      .q      (phi0_s)
   );

   assign valid   = bus.cpu_vda | bus.cpu_vpa;
   assign last    = cnt == CNT_LAST;
   // The synchroniser flops come out of reset as 0; until they have refilled,
   // a low phi0_s may be stale and must not be taken as the start of phi0 low,
   // otherwise the first high phase after reset could be joined part-way.
   assign settled = settle == SW'(SYNC_STAGES);

   always_comb begin
      nxt     = state;
      cnt_nxt = '0;
      case (state)
         HS_LO:       if (last) nxt = bbc_target(cfg_hs_en, valid, bus.cpu_adr_hi) ? BBC_WAIT_LO : HS_HI;
                      else      cnt_nxt = cnt + 1'b1;
         HS_HI:       if (last) nxt = HS_LO;
                      else      cnt_nxt = cnt + 1'b1;
         // Waiting for phi0 low first guarantees the rise we lock to is a fresh one.
         BBC_WAIT_LO: if (settled && !phi0_s) nxt = BBC_WAIT_HI;
         BBC_WAIT_HI: if (phi0_s) nxt = BBC_HI;
         BBC_HI:      if (!phi0_s) nxt = HS_LO;
         default:     nxt = BBC_WAIT_LO;
      endcase
      phi2_nxt = nxt inside {HS_HI, BBC_HI};
      // ram_sel is captured on the decision edge and held for the whole high phase.
      ram_nxt  = (nxt == HS_HI) && ((state == HS_LO) ? valid : ram);
   end

   always_ff @(posedge hsclk)
      if (!resetb) begin
         state  <= BBC_WAIT_LO;
         cnt    <= '0;
         phi2   <= 1'b0;
         ram    <= 1'b0;
         settle <= '0;
      end else begin
         state  <= nxt;
         cnt    <= cnt_nxt;
         phi2   <= phi2_nxt;
         ram    <= ram_nxt;
         if (!settled) settle <= settle + 1'b1;
      end

   assign bus.cpu_phi2  = phi2;
   assign bus.ram_sel   = ram;
   assign bus.bbc_cycle = is_bbc_state(state);

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb_clk_switch_ctrl: scoreboard bench for clk_switch_ctrl at HS_DIV 2, 1 and 15.
module tb_clk_switch_ctrl;

   typedef struct {
      logic b;
      logic r;
      int   lmin;
      int   lmax;
      int   hmin;
      int   hmax;
      bit   lag;
   } exp_t;

   logic       hsclk = 0, resetb = 0, bbc_phi0 = 0, en = 0, vda = 0, vpa = 0;
   logic [7:0] adr = 8'h00;
   int         tests = 0, fails = 0;
   exp_t       sb[$];
   time        t_rise = 0, lag0 = 0;
   int         hlen[3];
   bit         inbbc[3];
   bit         short_seen = 0;
   logic [2:0] phi2_w, bbc_w, ram_w;

   // hsclk period 10 units, phi0 period 80 units (8 hsclk), edges offset from hsclk edges.
   always #5 hsclk = ~hsclk;
   initial begin
      #2;
      forever begin
         bbc_phi0 = 1'b1;
         #40;
         bbc_phi0 = 1'b0;
         #40;
      end
   end

   clk_switch_ctrl_if bus0 ();
   clk_switch_ctrl_if bus1 ();
   clk_switch_ctrl_if bus2 ();

   assign bus0.cpu_adr_hi = adr;
   assign bus0.cpu_vda    = vda;
   assign bus0.cpu_vpa    = vpa;
   assign bus1.cpu_adr_hi = adr;
   assign bus1.cpu_vda    = vda;
   assign bus1.cpu_vpa    = vpa;
   assign bus2.cpu_adr_hi = adr;
   assign bus2.cpu_vda    = vda;
   assign bus2.cpu_vpa    = vpa;
   assign phi2_w = {bus2.cpu_phi2, bus1.cpu_phi2, bus0.cpu_phi2};
   assign bbc_w  = {bus2.bbc_cycle, bus1.bbc_cycle, bus0.bbc_cycle};
   assign ram_w  = {bus2.ram_sel, bus1.ram_sel, bus0.ram_sel};

   clk_switch_ctrl #(.HS_DIV(2), .SYNC_STAGES(2)) dut0 (
      .hsclk(hsclk), .resetb(resetb), .bbc_phi0(bbc_phi0), .cfg_hs_en(en), .bus(bus0));
   clk_switch_ctrl #(.HS_DIV(1), .SYNC_STAGES(2)) dut1 (
      .hsclk(hsclk), .resetb(resetb), .bbc_phi0(bbc_phi0), .cfg_hs_en(en), .bus(bus1));
   clk_switch_ctrl #(.HS_DIV(15), .SYNC_STAGES(2)) dut2 (
      .hsclk(hsclk), .resetb(resetb), .bbc_phi0(bbc_phi0), .cfg_hs_en(en), .bus(bus2));

   always @(posedge bbc_phi0) t_rise = $time;
   always @(posedge bus0.cpu_phi2) lag0 = $time - t_rise;

   // Flags any single-hsclk cpu_phi2 high pulse while in a BBC cycle, on any DUT.
   always @(negedge hsclk)
      for (int k = 0; k < 3; k++)
         if (phi2_w[k]) begin
            hlen[k]++;
            if (bbc_w[k]) inbbc[k] = 1'b1;
         end else begin
            if (hlen[k] == 1 && inbbc[k]) short_seen = 1'b1;
            hlen[k]  = 0;
            inbbc[k] = 1'b0;
         end

   // Called at a negedge: counts low samples up to the rise, then high samples up to the fall.
   task automatic measure(input int d, output int lo, output int hi, output logic b, output logic r, output bit to);
      lo = 0; hi = 0; b = 1'bx; r = 1'bx; to = 0;
      while (phi2_w[d] !== 1'b1) begin
         lo++;
         if (lo > 300) begin to = 1; return; end
         @(negedge hsclk);
      end
      b = bbc_w[d];
      r = ram_w[d];
      while (phi2_w[d] === 1'b1) begin
         hi++;
         if (hi > 300) begin to = 1; return; end
         @(negedge hsclk);
      end
   endtask

   task automatic check_next(input int d, input string nm);
      exp_t e;
      int   lo, hi;
      logic b, r;
      bit   to;
      measure(d, lo, hi, b, r, to);
      e = sb.pop_front();
      tests++;
      if (to) begin
         fails++;
         $display("FAIL %s: cpu_phi2 pulse not completed within bound (dut %0d)", nm, d);
         return;
      end
      tests++;
      if (b !== e.b) begin fails++; $display("FAIL %s bbc_cycle: got %b want %b", nm, b, e.b); end
      tests++;
      if (r !== e.r) begin fails++; $display("FAIL %s ram_sel: got %b want %b", nm, r, e.r); end
      tests++;
      if (hi < e.hmin || hi > e.hmax) begin
         fails++; $display("FAIL %s high_len: got %0d want %0d..%0d", nm, hi, e.hmin, e.hmax);
      end
      tests++;
      if (lo < e.lmin || lo > e.lmax) begin
         fails++; $display("FAIL %s low_len: got %0d want %0d..%0d", nm, lo, e.lmin, e.lmax);
      end
      if (e.lag) begin
         tests++;
         if (lag0 < 20 || lag0 > 30) begin
            fails++; $display("FAIL %s phi0_lag: got %0d want 20..30 time units", nm, lag0);
         end
      end
   endtask

   task automatic cyc(input int d, input string nm, input logic [7:0] a, input logic va, input logic pa, input logic e,
                      input logic xb, input logic xr, input int lmin, input int lmax, input int hmin, input int hmax, input bit lag);
      adr = a; vda = va; vpa = pa; en = e;
      sb.push_back('{xb, xr, lmin, lmax, hmin, hmax, lag});
      check_next(d, nm);
   endtask

   // Inputs change once more before the HS_LO decision edge; only the late values may count.
   task automatic late_cyc(input string nm, input logic [7:0] a0, input logic v0, input logic e0,
                           input logic [7:0] a1, input logic v1, input logic e1,
                           input logic xb, input logic xr, input int lmin, input int lmax, input bit lag);
      adr = a0; vda = v0; vpa = 1'b0; en = e0;
      sb.push_back('{xb, xr, lmin, lmax, xb ? 3 : 2, xb ? 4 : 2, lag});
      @(negedge hsclk);
      adr = a1; vda = v1; en = e1;
      check_next(0, nm);
   endtask

   task automatic check_reset_outputs(input string nm);
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (phi2_w[k] !== 1'b0) begin fails++; $display("FAIL %s phi2[%0d]: got %b want 0", nm, k, phi2_w[k]); end
         tests++;
         if (bbc_w[k] !== 1'b1) begin fails++; $display("FAIL %s bbc_cycle[%0d]: got %b want 1", nm, k, bbc_w[k]); end
         tests++;
         if (ram_w[k] !== 1'b0) begin fails++; $display("FAIL %s ram_sel[%0d]: got %b want 0", nm, k, ram_w[k]); end
      end
   endtask

   task automatic test_reset;
      resetb = 1'b0;
      adr = 8'h12; vda = 1'b1; vpa = 1'b0; en = 1'b0;
      repeat (4) @(negedge hsclk);
      check_reset_outputs("reset");
      resetb = 1'b1;
   endtask

   task automatic test_bbc_mode;
      for (int i = 0; i < 4; i++)
         cyc(0, "bbc_lock", 8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (i == 0) ? 0 : 3, (i == 0) ? 40 : 5, 3, 4, 1'b1);
   endtask

   task automatic test_fast;
      for (int i = 0; i < 4; i++)
         cyc(0, "fast_loop", 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 2, 2, 2, 1'b0);
   endtask

   task automatic test_decode;
      logic [7:0] a [7] = '{8'h7F, 8'h80, 8'h34, 8'hFE, 8'hFF, 8'h00, 8'hFE};
      logic       va[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic       pa[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         logic xb;
         xb = (va[i] | pa[i]) && a[i] >= 8'h80;
         cyc(0, "decode", a[i], va[i], pa[i], 1'b1, xb, !xb && (va[i] | pa[i]),
             xb ? 3 : 2, xb ? 12 : 2, xb ? 3 : 2, xb ? 4 : 2, xb);
      end
      cyc(0, "fast_resume", 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 2, 2, 2, 1'b0);
   endtask

   task automatic test_late_inputs;
      late_cyc("late_addr_fast", 8'hFE, 1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1, 1'b0);
      late_cyc("late_en_fast",   8'h12, 1'b1, 1'b0, 8'h12, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1, 1'b0);
      late_cyc("late_addr_bbc",  8'h12, 1'b1, 1'b1, 8'hFE, 1'b1, 1'b1, 1'b1, 1'b0, 2, 11, 1'b1);
      late_cyc("late_internal",  8'h12, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0);
   endtask

   task automatic test_phi0_high_and_reset;
      int n;
      n = 0;
      while (bbc_phi0 !== 1'b1 && n < 8) begin
         cyc(0, "pre_align", 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 2, 2, 2, 1'b0);
         n++;
      end
      cyc(0, "bbc_from_phi0_hi", 8'hFE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6, 11, 3, 4, 1'b1);
      en = 1'b0;
      n = 0;
      while (phi2_w[0] !== 1'b1 && n < 100) begin @(negedge hsclk); n++; end
      tests++;
      if (phi2_w[0] !== 1'b1) begin fails++; $display("FAIL reset_in_bbc_hi: no high phase, phi2 %b want 1", phi2_w[0]); end
      @(negedge hsclk);
      resetb = 1'b0;
      @(negedge hsclk);
      check_reset_outputs("reset_pulse");
      resetb = 1'b1;
      cyc(0, "post_reset_bbc", 8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 40, 3, 4, 1'b1);
   endtask

   task automatic test_hsdiv;
      adr = 8'h12; vda = 1'b1; vpa = 1'b0; en = 1'b1;
      for (int d = 1; d < 3; d++) begin
         int n, hs;
         hs = (d == 1) ? 1 : 15;
         n = 0;
         while (phi2_w[d] !== 1'b1 && n < 300) begin @(negedge hsclk); n++; end
         while (phi2_w[d] === 1'b1 && n < 600) begin @(negedge hsclk); n++; end
         for (int i = 0; i < 3; i++)
            cyc(d, (d == 1) ? "hsdiv1" : "hsdiv15", 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, hs, hs, hs, hs, 1'b0);
      end
   endtask

   task automatic test_pulse_width;
      tests++;
      if (short_seen) begin fails++; $display("FAIL bbc_pulse_width: 1-hsclk cpu_phi2 high seen %b want 0", short_seen); end
   endtask

   initial begin
      test_reset;
      test_bbc_mode;
      test_fast;
      test_decode;
      test_late_inputs;
      test_phi0_high_and_reset;
      test_hsdiv;
      test_pulse_width;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/clk_switch_ctrl.md
CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 The block SHALL have parameter HS_DIV, default 2: hsclk cycles per CPU clock phase (high or low) in high-speed cycles; legal range 1..15.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: flip-flop depth of the bbc_phi0 synchroniser.
REQ-003 Port hsclk, input, 1: the block's single clock; all state SHALL be updated on its rising edge.
REQ-004 Port resetb, input, 1: synchronous active-low reset.
REQ-005 Port bbc_phi0, input, 1: BBC 2 MHz phase-0 clock, asynchronous to hsclk.
REQ-006 Port cpu_adr_hi, input, 8: cpu_adr[15:8].
REQ-007 Port cpu_vda, input, 1: valid data address.
REQ-008 Port cpu_vpa, input, 1: valid program address.
REQ-009 Port cfg_hs_en, input, 1: high-speed mode enable; 0 = every cycle BBC-locked.
REQ-010 Port cpu_phi2, output, 1: registered CPU clock.
REQ-011 Port bbc_cycle, output, 1: current CPU cycle is routed to the BBC bus; used to gate bbc_rnw, the data latches and the address latch.
REQ-012 Port ram_sel, output, 1: current CPU cycle targets the fast SRAM.

Function
REQ-013 bbc_phi0 SHALL pass through a SYNC_STAGES synchroniser giving phi0_s; no other logic SHALL sample bbc_phi0.
REQ-014 FSM states SHALL be HS_LO, HS_HI, BBC_WAIT_LO, BBC_WAIT_HI and BBC_HI.
REQ-015 A cycle is BBC-targeted when cfg_hs_en=0, or (cpu_vda|cpu_vpa)=1 and cpu_adr_hi >= 8'h80; otherwise it is fast.
REQ-016 The target decision SHALL be made only on the last hsclk of HS_LO; inputs at all other times SHALL be ignored.
REQ-017 HS_LO: cpu_phi2=0 for HS_DIV hsclk cycles, then go to HS_HI if fast, or to BBC_WAIT_LO if BBC-targeted (phi1 stretched).
REQ-018 HS_HI: cpu_phi2=1 for HS_DIV hsclk cycles, then go to HS_LO.
REQ-019 BBC_WAIT_LO: cpu_phi2=0; go to BBC_WAIT_HI on the first hsclk with phi0_s=0.
REQ-020 BBC_WAIT_HI: cpu_phi2=0; go to BBC_HI on the first hsclk with phi0_s=1, so a rising phi0 edge is never joined mid-phase.
REQ-021 BBC_HI: cpu_phi2=1 until phi0_s=0, then go to HS_LO with the phase counter cleared.
REQ-022 cpu_phi2 SHALL be driven directly from a flop; its high time in BBC_HI SHALL equal phi0_s high time to within 1 hsclk.
REQ-023 bbc_cycle SHALL be 1 in BBC_WAIT_LO, BBC_WAIT_HI and BBC_HI, and 0 otherwise.
REQ-024 ram_sel SHALL be 1 from the HS_LO->HS_HI transition until the following HS_LO is entered, but only when the decoded cycle had (cpu_vda|cpu_vpa)=1; internal cycles SHALL leave ram_sel=0.
REQ-025 The phase counter SHALL be width $clog2(HS_DIV+1), SHALL wrap only by explicit clear on state change, and SHALL never overflow.
REQ-026 A cfg_hs_en change mid-cycle SHALL take effect only at the next HS_LO decision point.
REQ-027 If phi0_s is already 1 on entry to BBC_WAIT_LO, the FSM SHALL wait out that phase.

Reset
REQ-028 With resetb=0 at a hsclk edge: state=BBC_WAIT_LO, counter=0, cpu_phi2=0, bbc_cycle=1, ram_sel=0, synchroniser flops=0.
REQ-029 Reset asserted mid-cycle SHALL abort the cycle on that edge; after release, the first cpu_phi2 high SHALL align to a full phi0 high phase.

Structure
REQ-030 Package clk_switch_pkg SHALL hold the state enum, BBC_REGION_BASE=8'h80 and the default HS_DIV.
REQ-031 The synchroniser SHALL be a separate sub-module, sync_bit, parameterised by stage count, so that it can be reused for rdy/irqb.

Verification
REQ-032 hsclk 16 MHz, phi0 2 MHz, cfg_hs_en=0, reset released -> every cpu_phi2 high pulse 3-4 hsclk long, lagging phi0 rise by 2-3 hsclk; bbc_cycle constant 1.
REQ-033 cfg_hs_en=1, cpu_adr_hi=8'h12, vda=1 -> cpu_phi2 period 4 hsclk (2 high, 2 low), ram_sel=1 in each high phase, bbc_cycle=0.
REQ-034 Fast loop, then one cycle with cpu_adr_hi=8'hFE, vda=1 -> stretched low, one phi0-aligned high phase, bbc_cycle=1 only for that cycle, fast cycles resume.
REQ-035 cpu_adr_hi=8'hFE with vda=vpa=0 -> fast internal cycle, bbc_cycle=0, ram_sel=0.
REQ-036 BBC-targeted decision taken while phi0_s=1 -> no cpu_phi2 rise until after a full phi0 low; resetb pulsed low for 1 hsclk inside BBC_HI -> cpu_phi2=0 on the next edge, then REQ-029 holds.
REQ-037 HS_DIV=1 and HS_DIV=15 runs -> period 2 and 30 hsclk respectively, no counter overflow, assertion: cpu_phi2 never shows a high pulse of 1 hsclk in BBC states.
